// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives the req/ack imem port and queues words for decode.
// Define FETCH_STATS_EN to add the stat_fetched / stat_discarded counters.
module if_fetch_unit #(
   parameter int unsigned QUEUE_DEPTH = 2,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_address,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] PC,
   output logic [31:0] instruction
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] stat_fetched,
   output logic [31:0] stat_discarded
`endif
);

   localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t             state_q, state_d;
   logic               req_d;
   logic [31:0]        addr_d;
   logic [31:0]        fetch_pc_q, fetch_pc_d;
   logic               discard_q, discard_d;
   logic [31:0]        target;

   logic [31:0]        q_pc  [QUEUE_DEPTH];
   logic [31:0]        q_ins [QUEUE_DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   logic [CNT_W-1:0]   count, cnt_post;
   logic               ack_v, push, pop;

   // Acks are only meaningful against a live request; stale ones are ignored.
   assign ack_v    = imem_ack && imem_req;
   assign target   = branch_address & 32'hFFFF_FFFC;
   assign push     = ack_v && !discard_q && !branch_taken;
   assign pop      = if_valid && !freeze && !branch_taken;
   assign cnt_post = branch_taken ? '0 : CNT_W'(count + CNT_W'(push) - CNT_W'(pop));

   assign if_valid    = (count != '0);
   assign PC          = if_valid ? q_pc[rd_ptr]  : 32'h0;
   assign instruction = if_valid ? q_ins[rd_ptr] : 32'h0;

   // Request FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next state: issue when space is reserved; a redirect always restarts fetching
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (branch_taken || count < DEPTH_C) state_d = S_WAIT;
         S_WAIT: if (ack_v && !branch_taken && !discard_q && cnt_post >= DEPTH_C)
                    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Next request/PC/discard values; address only moves when a new request starts
   always_comb begin
      req_d      = (state_d == S_WAIT);
      addr_d     = imem_addr;
      fetch_pc_d = fetch_pc_q;
      discard_d  = discard_q;
      if (branch_taken) begin
         fetch_pc_d = target;
         discard_d  = (state_q == S_WAIT) && !ack_v;
      end else if (ack_v) begin
         discard_d = 1'b0;
         if (!discard_q) fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (req_d && (state_q == S_IDLE || ack_v)) addr_d = fetch_pc_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         imem_req   <= 1'b0;
         imem_addr  <= 32'h0;
         fetch_pc_q <= RESET_PC;
         discard_q  <= 1'b0;
         count      <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
      end else begin
         imem_req   <= req_d;
         imem_addr  <= addr_d;
         fetch_pc_q <= fetch_pc_d;
         discard_q  <= discard_d;
         count      <= cnt_post;
         if (branch_taken) begin
            rd_ptr <= wr_ptr;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // Queue storage holds {address+4, word}
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]  <= imem_addr + 32'd4;
         q_ins[wr_ptr] <= imem_rdata;
      end
   end

`ifdef FETCH_STATS_EN
   logic drop;
   assign drop = ack_v && (discard_q || branch_taken);

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_fetched   <= 32'h0;
         stat_discarded <= 32'h0;
      end else begin
         stat_fetched   <= stat_fetched + 32'(push);
         stat_discarded <= stat_discarded + 32'(drop) + (branch_taken ? 32'(count) : 32'h0);
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized run against a program-order model.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst, freeze, branch_taken;
   logic [31:0] branch_address;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        if_valid;
   logic [31:0] PC, instruction;
`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched, stat_discarded;
`endif

   if_fetch_unit #(.QUEUE_DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
      .branch_address(branch_address), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
      .PC(PC), .instruction(instruction)
`ifdef FETCH_STATS_EN
      , .stat_fetched(stat_fetched), .stat_discarded(stat_discarded)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: acks after lat wait cycles, data = address ^ key; stray can inject a bogus ack
   logic [1:0]  lat_fixed, lat_rand, lat_eff;
   logic        rand_lat, stray, mem_ack;
   logic [2:0]  wcnt;
   logic [31:0] key;
   assign lat_eff    = rand_lat ? lat_rand : lat_fixed;
   assign mem_ack    = imem_req && (wcnt >= {1'b0, lat_eff});
   assign imem_ack   = mem_ack || stray;
   assign imem_rdata = imem_ack ? (imem_addr ^ key) : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (rst) begin
         wcnt     <= 3'd0;
         lat_rand <= 2'd0;
      end else begin
         if (imem_req && !imem_ack) wcnt <= wcnt + 3'd1;
         else                       wcnt <= 3'd0;
         if (imem_req && imem_ack) lat_rand <= 2'($urandom_range(0, 3));
      end
   end

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   logic [31:0] got [$];
   logic [31:0] exp_pc, h_pc, h_ins, w_addr, ba, first_addr, first_pc, first_ins;
   logic        hold, wchk, frz, br, stray_n, saw_bad, have_addr, have_pc, found;
   int          consumed, k;

   initial begin
      rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_address = 32'h0;
      stray = 1'b1; key = 32'h0; rand_lat = 1'b0; lat_fixed = 2'd0;

      // Reset values with stray acks present, then zero-wait stream
      do_reset();
      rst = 1'b1;
      chk("rst_req",   32'(imem_req), 32'd0);
      chk("rst_addr",  imem_addr, 32'h0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_pc",    PC, 32'h0);
      chk("rst_ins",   instruction, 32'h0);
      rst = 1'b0;
      tick();
      chk("req_rise",  32'(imem_req), 32'd1);
      chk("req_addr0", imem_addr, 32'h0);
      chk("no_stray",  32'(if_valid), 32'd0);
      stray = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("zw_valid", 32'(if_valid), 32'd1);
         chk("zw_pc",    PC, 32'(4 * (i + 1)));
         chk("zw_ins",   instruction, 32'(4 * i));
      end

      // Three wait states per request
      lat_fixed = 2'd3;
      do_reset();
      for (int i = 1; i <= 13; i++) begin
         tick();
         chk("ws_req",   32'(imem_req), 32'd1);
         chk("ws_addr",  imem_addr, 32'(4 * ((i - 1) / 4)));
         chk("ws_valid", 32'(if_valid), 32'((i >= 5) && (i % 4 == 1)));
         if (if_valid) chk("ws_pc", PC, 32'(4 * ((i - 1) / 4)));
      end

      // Freeze holds head; fetching stops when full; drain in order
      lat_fixed = 2'd0;
      do_reset();
      tick();
      tick();
      chk("fz_head", PC, 32'h4);
      freeze = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("fz_valid", 32'(if_valid), 32'd1);
         chk("fz_pc",    PC, 32'h4);
         chk("fz_req",   32'(imem_req), 32'd0);
      end
`ifdef FETCH_STATS_EN
      chk("st_fetched",   stat_fetched, 32'd2);
      chk("st_discarded", stat_discarded, 32'd0);
`endif
      freeze = 1'b0;
      got.delete();
      for (int i = 0; i < 10; i++) begin
         if (if_valid) got.push_back(PC);
         tick();
      end
      chk("fz_drain_n", 32'(got.size() >= 3), 32'd1);
      if (got.size() >= 3) begin
         chk("fz_drain0", got[0], 32'h4);
         chk("fz_drain1", got[1], 32'h8);
         chk("fz_drain2", got[2], 32'hC);
      end

      // Redirect overrides freeze and flushes a full queue
      freeze = 1'b1;
      do_reset();
      repeat (5) tick();
      branch_taken = 1'b1; branch_address = 32'h0000_0200;
      tick();
      branch_taken = 1'b0;
      chk("fl_valid", 32'(if_valid), 32'd0);
      chk("fl_req",   32'(imem_req), 32'd1);
      chk("fl_addr",  imem_addr, 32'h200);
`ifdef FETCH_STATS_EN
      chk("fl_st_discarded", stat_discarded, 32'd2);
      chk("fl_st_fetched",   stat_fetched, 32'd2);
`endif
      tick();
      chk("fl_pc", PC, 32'h204);
      freeze = 1'b0;

      // Redirect while request to 0x10 is outstanding
      lat_fixed = 2'd2;
      do_reset();
      found = 1'b0; k = 0;
      while (!found && k < 60) begin
         tick();
         k++;
         if (imem_req && imem_addr == 32'h10 && !imem_ack) found = 1'b1;
      end
      chk("rd_found", 32'(found), 32'd1);
      branch_taken = 1'b1; branch_address = 32'h0000_0103;
      tick();
      branch_taken = 1'b0;
      chk("rd_flush", 32'(if_valid), 32'd0);
      chk("rd_hold",  imem_addr, 32'h10);
      saw_bad = 1'b0; have_addr = 1'b0; have_pc = 1'b0;
      first_addr = 32'h0; first_pc = 32'h0; first_ins = 32'h0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (if_valid && PC == 32'h14) saw_bad = 1'b1;
         if (!have_addr && imem_req && imem_addr != 32'h10) begin
            have_addr = 1'b1; first_addr = imem_addr;
         end
         if (!have_pc && if_valid) begin
            have_pc = 1'b1; first_pc = PC; first_ins = instruction;
         end
      end
      chk("rd_no_wrong", 32'(saw_bad), 32'd0);
      chk("rd_addr",     first_addr, 32'h100);
      chk("rd_pc",       first_pc, 32'h104);
      chk("rd_ins",      first_ins, 32'h100);

      // Redirect coinciding with the ack for 0x8, then redirect into the wrap region
      lat_fixed = 2'd0;
      do_reset();
      found = 1'b0; k = 0;
      while (!found && k < 20) begin
         tick();
         k++;
         if (imem_req && imem_addr == 32'h8) found = 1'b1;
      end
      chk("co_found", 32'(found && imem_ack), 32'd1);
      branch_taken = 1'b1; branch_address = 32'h0000_0040;
      tick();
      branch_taken = 1'b0;
      chk("co_addr",  imem_addr, 32'h40);
      chk("co_valid", 32'(if_valid), 32'd0);
      tick();
      chk("co_pc",  PC, 32'h44);
      chk("co_ins", instruction, 32'h40);

      branch_taken = 1'b1; branch_address = 32'hFFFF_FFF8;
      tick();
      branch_taken = 1'b0;
      chk("wr_addr0", imem_addr, 32'hFFFF_FFF8);
      tick();
      chk("wr_addr1", imem_addr, 32'hFFFF_FFFC);
      chk("wr_pc1",   PC, 32'hFFFF_FFFC);
      chk("wr_ins1",  instruction, 32'hFFFF_FFF8);
      tick();
      chk("wr_addr2", imem_addr, 32'h0);
      chk("wr_val2",  32'(if_valid), 32'd1);
      chk("wr_pc2",   PC, 32'h0);
      chk("wr_ins2",  instruction, 32'hFFFF_FFFC);
      tick();
      chk("wr_pc3",   PC, 32'h4);
      chk("wr_ins3",  instruction, 32'h0);

      // Randomized run: decode must see the program-order stream restarting at each target
      key = $urandom;
      rand_lat = 1'b1;
      do_reset();
      exp_pc = 32'h4; hold = 1'b0; wchk = 1'b0; consumed = 0;
      h_pc = 32'h0; h_ins = 32'h0; w_addr = 32'h0;
      for (int c = 0; c < 1500; c++) begin
         if (hold) begin
            chk("rnd_hold_v",   32'(if_valid), 32'd1);
            chk("rnd_hold_pc",  PC, h_pc);
            chk("rnd_hold_ins", instruction, h_ins);
         end
         if (wchk) begin
            chk("rnd_req_stable",  32'(imem_req), 32'd1);
            chk("rnd_addr_stable", imem_addr, w_addr);
         end
         chk("rnd_align", 32'(imem_addr[1:0]), 32'd0);
         frz     = ($urandom_range(0, 3) == 0);
         br      = ($urandom_range(0, 24) == 0);
         ba      = $urandom;
         stray_n = !imem_req && ($urandom_range(0, 7) == 0);
         hold    = if_valid && frz && !br;
         h_pc    = PC;
         h_ins   = instruction;
         wchk    = imem_req && !(mem_ack || stray_n);
         w_addr  = imem_addr;
         if (if_valid && !frz && !br) begin
            chk("rnd_pc",  PC, exp_pc);
            chk("rnd_ins", instruction, (exp_pc - 32'd4) ^ key);
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         if (br) exp_pc = (ba & 32'hFFFF_FFFC) + 32'd4;
         freeze = frz; branch_taken = br; branch_address = ba; stray = stray_n;
         tick();
      end
      freeze = 1'b0; branch_taken = 1'b0; stray = 1'b0;
      chk("rnd_progress", 32'(consumed >= 100), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
